// File: rtl/sobel_window_gen.sv
// ---------------------------------------------------------------------------
// sobel_window_gen
//
// Streaming 3x3 neighbourhood generator for a Sobel gradient stage.
// Pixels arrive one per valid cycle in raster order. Two line buffers hold
// the previous two image lines. For every interior pixel the eight
// neighbours of the window centre (centre itself omitted) are presented as
// registered outputs with a one-cycle valid strobe.
//
// Handshake: a pixel is accepted on every rising clk edge where in_valid=1.
// There is no backpressure. win_valid is a single-cycle strobe, asserted one
// cycle after accepting a pixel at col>=2,row>=2; p* hold their value
// otherwise.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_pixel is valid this cycle
//   in_sof     qualified by in_valid; forces the pixel to position (0,0)
//   in_pixel   8-bit pixel
//   win_valid  p0..p8 hold a complete window this cycle
//   p0,p1,p2   top row    (left, centre, right)
//   p3,p5      middle row (left, right)
//   p6,p7,p8   bottom row (left, centre, right)
//   frame_done one-cycle pulse after the last pixel of a frame is accepted
// ---------------------------------------------------------------------------
module sobel_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [7:0] in_pixel,
    output logic       win_valid,
    output logic [7:0] p0,
    output logic [7:0] p1,
    output logic [7:0] p2,
    output logic [7:0] p3,
    output logic [7:0] p5,
    output logic [7:0] p6,
    output logic [7:0] p7,
    output logic [7:0] p8,
    output logic       frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
    localparam logic [CW-1:0] MIN_COL  = CW'(2);
    localparam logic [RW-1:0] MIN_ROW  = RW'(2);

    // Position counters: position of the next pixel to be accepted
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    // Line buffers: r_lb1 holds row-1, r_lb2 holds row-2
    logic [7:0] r_lb1 [IMG_W];
    logic [7:0] r_lb2 [IMG_W];

    // Window shift registers. Only the two older columns are stored; the
    // newest column comes straight from the line buffer reads and in_pixel.
    // Index 0 is the leftmost column.
    logic [7:0] r_top0, r_top1;
    logic [7:0] r_mid0, r_mid1;
    logic [7:0] r_bot0, r_bot1;

    logic          w_accept;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [7:0]    w_lb1_rd;
    logic [7:0]    w_lb2_rd;
    logic          w_win;
    logic          w_last;

    assign w_accept = in_valid;

    // in_sof relocates the accepted pixel to (0,0); at (0,0) it is a no-op
    assign w_col = in_sof ? '0 : r_col;
    assign w_row = in_sof ? '0 : r_row;

    // Read-before-write: these reads see the contents before this pixel's
    // update at the clock edge
    assign w_lb1_rd = r_lb1[w_col];
    assign w_lb2_rd = r_lb2[w_col];

    // col>=2 keeps every window inside one line; row>=2 guarantees both
    // line buffers hold data from the current frame
    assign w_win  = w_accept && (w_col >= MIN_COL) && (w_row >= MIN_ROW);
    assign w_last = w_accept && (w_col == LAST_COL) && (w_row == LAST_ROW);

    // Position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col == LAST_COL) begin
                r_col <= '0;
                r_row <= (w_row == LAST_ROW) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    // Line buffer storage; contents need no reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[w_col] <= w_lb1_rd;
            r_lb1[w_col] <= in_pixel;
        end
    end

    // Window column shift on every accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top0 <= '0;
            r_top1 <= '0;
            r_mid0 <= '0;
            r_mid1 <= '0;
            r_bot0 <= '0;
            r_bot1 <= '0;
        end else if (w_accept) begin
            r_top0 <= r_top1;
            r_top1 <= w_lb2_rd;
            r_mid0 <= r_mid1;
            r_mid1 <= w_lb1_rd;
            r_bot0 <= r_bot1;
            r_bot1 <= in_pixel;
        end
    end

    // Output registers load the shifted window only when it is complete,
    // so p* stay stable across border pixels and idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            p0         <= '0;
            p1         <= '0;
            p2         <= '0;
            p3         <= '0;
            p5         <= '0;
            p6         <= '0;
            p7         <= '0;
            p8         <= '0;
        end else begin
            win_valid  <= w_win;
            frame_done <= w_last;
            if (w_win) begin
                p0 <= r_top0;
                p1 <= r_top1;
                p2 <= w_lb2_rd;
                p3 <= r_mid0;
                p5 <= w_lb1_rd;
                p6 <= r_bot0;
                p7 <= r_bot1;
                p8 <= in_pixel;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// ---------------------------------------------------------------------------
// tb_sobel_window_gen
//
// Bench for sobel_window_gen with a 5x4 frame whose pixel value is
// 16*row+col. Expected windows come from a hand-computed table.
// ---------------------------------------------------------------------------
module tb_sobel_window_gen;

    localparam int IMG_W = 5;
    localparam int IMG_H = 4;

    typedef struct {
        logic [7:0]  trig;   // pixel whose acceptance completes the window
        logic [63:0] win;    // {p0,p1,p2,p3,p5,p6,p7,p8}
    } vec_t;

    vec_t tab [6];

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_pixel = 8'h00;
    logic       win_valid, frame_done;
    logic [7:0] p0, p1, p2, p3, p5, p6, p7, p8;

    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_pixel  (in_pixel),
        .win_valid (win_valid),
        .p0        (p0),
        .p1        (p1),
        .p2        (p2),
        .p3        (p3),
        .p5        (p5),
        .p6        (p6),
        .p7        (p7),
        .p8        (p8),
        .frame_done(frame_done)
    );

    // ---------------- scoreboard ----------------
    logic [71:0] exp_q [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          win_cnt = 0;
    int          fd_cnt = 0;
    logic        acc_v = 1'b0;
    logic [7:0]  acc_p = 8'h00;
    logic [63:0] last_exp = 64'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Record what the DUT accepts at each edge
    always @(posedge clk) begin
        acc_v <= in_valid && rst_n;
        acc_p <= in_pixel;
    end

    // Monitor: outputs are sampled on the falling edge
    always @(negedge clk) begin
        logic [63:0] obs;
        logic [71:0] e;
        logic        exp_wv, exp_fd;
        obs = {p0, p1, p2, p3, p5, p6, p7, p8};
        if (!rst_n) begin
            last_exp = 64'h0;
        end else begin
            exp_wv = acc_v && (acc_p[3:0] >= 4'd2) && (acc_p[7:4] >= 4'd2);
            exp_fd = acc_v && (acc_p == 8'h34);
            check("win_valid", {63'h0, win_valid}, {63'h0, exp_wv});
            check("frame_done", {63'h0, frame_done}, {63'h0, exp_fd});
            if (frame_done) fd_cnt++;
            if (win_valid) begin
                win_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_window", obs, 64'hx);
                end else begin
                    e = exp_q.pop_front();
                    check("window_trigger", {56'h0, acc_p}, {56'h0, e[71:64]});
                    check("window_pixels", obs, e[63:0]);
                    last_exp = e[63:0];
                end
            end else begin
                check("p_held", obs, last_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] pix, input logic sof);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_pixel = pix;
        in_sof   = sof;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_sof   = $urandom_range(0, 1);
            in_pixel = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < 6; i++) exp_q.push_back({tab[i].trig, tab[i].win});
    endtask

    task automatic send_frame(input logic gaps, input logic sof_first);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                send(8'(16 * r + c), sof_first && (r == 0) && (c == 0));
                if (gaps) idle(1);
            end
    endtask

    task automatic end_test(input string name, input int win0, input int fd0,
                            input int wins, input int fds);
        idle(3);
        check({name, "_windows"}, 64'(win_cnt - win0), 64'(wins));
        check({name, "_frame_done"}, 64'(fd_cnt - fd0), 64'(fds));
        check({name, "_queue_left"}, 64'(exp_q.size()), 64'h0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0, f0;

        tab[0] = '{8'h22, 64'h00_01_02_10_12_20_21_22};
        tab[1] = '{8'h23, 64'h01_02_03_11_13_21_22_23};
        tab[2] = '{8'h24, 64'h02_03_04_12_14_22_23_24};
        tab[3] = '{8'h32, 64'h10_11_12_20_22_30_31_32};
        tab[4] = '{8'h33, 64'h11_12_13_21_23_31_32_33};
        tab[5] = '{8'h34, 64'h12_13_14_22_24_32_33_34};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_win_valid", {63'h0, win_valid}, 64'h0);
        check("reset_frame_done", {63'h0, frame_done}, 64'h0);
        check("reset_p", {p0, p1, p2, p3, p5, p6, p7, p8}, 64'h0);
        rst_n = 1'b1;
        idle(2);

        // Nominal frame, continuous, including the line wrap into row 3;
        // in_sof at (0,0) must not change anything
        w0 = win_cnt; f0 = fd_cnt;
        push_frame();
        send_frame(1'b0, 1'b1);
        end_test("nominal", w0, f0, 6, 1);

        // Bubbles: in_valid toggling
        w0 = win_cnt; f0 = fd_cnt;
        push_frame();
        send_frame(1'b1, 1'b0);
        end_test("bubbles", w0, f0, 6, 1);

        // Mid-frame in_sof after 9 pixels
        w0 = win_cnt; f0 = fd_cnt;
        for (int i = 0; i < 9; i++) send(8'(16 * (i / 5) + (i % 5)), 1'b0);
        push_frame();
        send_frame(1'b0, 1'b1);
        end_test("sof_restart", w0, f0, 6, 1);

        // Async reset during row 2 after the first window
        w0 = win_cnt; f0 = fd_cnt;
        exp_q.push_back({tab[0].trig, tab[0].win});
        for (int i = 0; i < 13; i++) send(8'(16 * (i / 5) + (i % 5)), 1'b0);
        idle(2);
        rst_n = 1'b0;
        #1;
        check("async_reset_win_valid", {63'h0, win_valid}, 64'h0);
        check("async_reset_p", {p0, p1, p2, p3, p5, p6, p7, p8}, 64'h0);
        idle(2);
        check("in_reset_frame_done", {63'h0, frame_done}, 64'h0);
        rst_n = 1'b1;
        push_frame();
        send_frame(1'b0, 1'b0);
        end_test("reset_restart", w0, f0, 7, 1);

        // Back-to-back frames, no gap, no in_sof
        w0 = win_cnt; f0 = fd_cnt;
        push_frame();
        push_frame();
        send_frame(1'b0, 1'b0);
        send_frame(1'b0, 1'b0);
        end_test("back_to_back", w0, f0, 12, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Streaming 3x3 neighbourhood generator that sits directly upstream of the Sobel gradient stage.
- Accepts one 8-bit pixel per valid cycle in raster order.
- Stores the two previous image lines in line buffers.
- Presents the eight neighbours p0..p8 (centre p4 omitted) of every interior pixel as registered outputs, with a valid strobe, to the combinational Sobel kernel.

Parameters:
- IMG_W, 64, pixels per line; legal range 3..4096.
- IMG_H, 64, lines per frame; legal range 3..4096.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_pixel valid this cycle; no backpressure, every valid pixel is consumed
- in_sof  input  1  qualified by in_valid; marks pixel (0,0) of a frame
- in_pixel  input  8  pixel value
- win_valid  output  1  p0..p8 hold a complete window this cycle
- p0,p1,p2  output  8 each  top row: left, centre, right
- p3,p5  output  8 each  middle row: left, right
- p6,p7,p8  output  8 each  bottom row: left, centre, right
- frame_done  output  1  one-cycle pulse after the last pixel (IMG_W-1, IMG_H-1) is accepted

Behaviour:
- Reset state:
  - Async reset drives win_valid=0, frame_done=0, all p* = 0.
  - col=0, row=0; window shift registers cleared.
  - Line buffer RAM contents are don't-care.
- Counters:
  - col and row are $clog2(IMG_W) and $clog2(IMG_H) bits wide.
  - The accepted pixel is at (col,row). col increments per accepted pixel and wraps at IMG_W-1, which increments row.
  - row wraps at IMG_H-1 to 0, so the next frame is implicit and in_sof is not required.
- Line buffers:
  - Two IMG_W-deep by 8-bit buffers addressed by col.
  - LB1 holds row-1; LB2 holds row-2.
  - On an accepted pixel: read LB1[col] and LB2[col], then write LB2[col] <= LB1[col] and LB1[col] <= in_pixel in the same cycle (read-before-write).
  - Synchronous-read or register-based implementation is free, provided output timing below holds.
- Window:
  - A 3-column shift register per row (top=LB2 data, mid=LB1 data, bottom=in_pixel) shifts only on accepted pixels.
  - The rightmost column is the newest pixel.
- Output validity and latency:
  - win_valid=1 exactly one cycle after accepting a pixel with col>=2 and row>=2. The window centre is then (col-1,row-1).
  - Per frame, (IMG_W-2)*(IMG_H-2) windows are produced. Border pixels produce no window.
  - No window spans a line wrap or a frame wrap.
- Timing:
  - win_valid is a single-cycle pulse per window; it is 0 in cycles following in_valid=0.
  - p* hold their last value when win_valid=0.
- frame_done: asserts one cycle after accepting (IMG_W-1,IMG_H-1), coincident with the last win_valid.
- in_sof:
  - Applies when in_valid && in_sof. The pixel is forced to position (0,0), and counters continue from there.
  - Any partial frame is abandoned with no frame_done. Stale line-buffer data is never emitted, because windows require row>=2.
  - in_sof at (0,0) is a no-op.
- Reset mid-frame: outputs clear immediately (asynchronous). The next accepted pixel is (0,0).
- Arithmetic: pure data movement; no pixel modification.

Test Plan:
- Nominal window:
  - Stimulus: IMG_W=5, IMG_H=4; pixel=16*row+col, in_valid continuous.
  - Response: exactly 6 win_valid pulses, the first one cycle after pixel 0x22 is accepted, with p0..p8 = 00,01,02,10,12,20,21,22.
  - Last window: p0=12, p8=34, with frame_done in the same cycle.
- Line wrap:
  - Same frame as above.
  - Response: no win_valid after accepting 0x30 or 0x31. The first row-3 window, on 0x32, has p0=10, p2=12, p6=30, p8=32.
- Bubbles:
  - Same frame with in_valid toggling 1,0,1,0.
  - Response: identical window sequence and values; win_valid=0 during gaps; p* held.
- Mid-frame in_sof:
  - After 9 pixels, assert in_sof with pixel 0x00 and restart the frame.
  - Response: no frame_done for the aborted frame; the first window is again 00..22 at the expected cycle.
- Async reset mid-frame:
  - Drop rst_n during row 2, then release and resend a full frame.
  - Response: all outputs 0 during reset; the fresh frame yields the same 6 windows as the nominal test.
- Back-to-back frames:
  - Two frames with no gap and no in_sof.
  - Response: 12 windows total, two frame_done pulses, and no window mixing frame-1 and frame-2 rows.
